pir_sensor_scanner: RTL and testbench
=====================================

Name: pir_sensor_scanner

Overview:
Upstream front-end for the PIR motion controller. It time-multiplexes one shared 7-bit ADC across the three PIR channels and clamps each sample to the valid level range. It applies a per-channel running average and drives the registered pir_sensor_1..3 levels that the motion controller compares against its trigger threshold.

Parameters:
SAMPLE_DIV, 50, clock cycles between scan starts; legal range ≥ 16.
AVG_LOG2, 2, log2 of the averaging depth (depth = 4 at default).
ADC_TIMEOUT, 31, maximum cycles spent in CONVERT before a channel is abandoned.
MAX_LEVEL, 100, upper clamp applied to raw samples.

Ports:
clk  input  1  system clock; the block uses this one clock only.
rst_n  input  1  reset, asynchronous and active-low.
enable  input  1  scanning enable; the system turn switch drives it.
adc_data  input  7  raw conversion result; sampled only when adc_done=1.
adc_done  input  1  single-cycle conversion-complete strobe.
adc_start  output  1  single-cycle conversion request.
adc_ch  output  2  channel select; values 0..2; stable from START until that channel's ACCUM.
pir_sensor_1  output  7  averaged level, channel 0.
pir_sensor_2  output  7  averaged level, channel 1.
pir_sensor_3  output  7  averaged level, channel 2.
sample_valid  output  1  one-cycle pulse after all three outputs are updated.
adc_fault  output  1  sticky flag; set on any ADC timeout.

Behaviour:
- Reset (rst_n=0, asynchronous): every output goes to 0. This covers adc_start, adc_ch, all three pir_sensor outputs, sample_valid and adc_fault. Reset also clears all history registers, sums, the tick counter, the timeout counter and the channel index. The state machine enters IDLE.
- Tick counter: counts 0..SAMPLE_DIV-1 while enable=1. tick=1 when the count equals SAMPLE_DIV-1, then the counter wraps to 0.
  - A tick that arrives while a scan is in progress is dropped. Ticks are never queued.
- State machine (one-hot encoded): IDLE, START, CONVERT, ACCUM, NEXT.
  - IDLE: waits for tick with enable=1, then goes to START with channel index 0.
  - START: adc_start=1 for this cycle only; adc_ch = channel index. The timeout counter clears. Next state is CONVERT.
  - CONVERT: on the edge where adc_done is sampled 1, capture min(adc_data, MAX_LEVEL) and go to ACCUM.
    - If the timeout counter reaches ADC_TIMEOUT without adc_done, set adc_fault, skip the history update and go to NEXT.
  - ACCUM: update the selected channel's running average (see averaging below) and register the result onto that pir_sensor output. Next state is NEXT.
  - NEXT: if the channel index is 2, clear it to 0, assert sample_valid for the following cycle and go to IDLE. Otherwise increment the channel index and go to START.
- Averaging, per channel:
  - History is a shift register of depth 2^AVG_LOG2 holding 7-bit samples.
  - The running sum is 7+AVG_LOG2 bits wide; new_sum = sum − oldest + new_sample.
  - output = new_sum >> AVG_LOG2, truncating.
  - The output cannot exceed MAX_LEVEL, and there is no overflow by construction.
  - History starts at zero, so the first samples are diluted; there is no warm-up bypass.
- Latency:
  - pir_sensor_k updates on the second rising edge after adc_done is sampled high.
  - Minimum scan length is 12 cycles (4 per channel at 1-cycle ADC latency).
- Strobe handling: adc_done outside CONVERT is ignored. An adc_done arriving in the same cycle the timeout fires counts as done, and adc_fault is not set.
- enable=0 in any state:
  - The next edge enters IDLE with adc_start=0.
  - The tick counter and channel index clear.
  - Outputs, history and adc_fault hold.
  - A conversion in flight is discarded.
  - Re-enabling starts the next scan at channel 0 after a full SAMPLE_DIV period.
- adc_fault is cleared only by reset.

Decomposition:
- pir_pkg holds:
  - the state one-hot constants;
  - NUM_CH=3;
  - the MAX_LEVEL default;
  - the level width (7), so that this block and the motion controller share it.
- Sub-module pir_avg_channel holds one channel's history and running sum. Its ports are clk, rst_n, load, sample[6:0] and level[6:0], and it is instantiated three times. The scanner owns the FSM, the tick counter, the timeout counter and the clamp.

Test Plan:
- Reset with rst_n low mid-CONVERT -> all outputs 0 asynchronously; the first scan after release waits a full SAMPLE_DIV.
- ADC model returns 40 on every channel with 3-cycle latency -> after scan 1 all levels read 10, after scan 4 all levels read 40; sample_valid pulses once per scan, 1 cycle wide.
- Channel 1 returns 120 on every scan -> pir_sensor_2 reads 25, 50, 75, then 100 and stays at 100 (clamped).
- Channel 0 sequence 0,0,0,0,80 -> pir_sensor_1 reads 20 after the fifth scan.
- Channel 2 never asserts adc_done -> adc_fault=1 after ADC_TIMEOUT cycles in CONVERT; pir_sensor_3 is unchanged; sample_valid still pulses; the next scan proceeds normally.
- enable dropped during CONVERT on channel 1 -> next cycle adc_start=0, state IDLE, levels hold; a late adc_done is ignored; after re-enable the scan restarts at adc_ch=0.

Source files
------------

// File: rtl/pir_pkg.sv
// rtl/pir_pkg.sv - shared constants and state encoding for the PIR scanner
// Contents:
//   LEVEL_W       width of a PIR level, shared with the motion controller
//   NUM_CH        number of PIR channels scanned by the shared ADC
//   MAX_LEVEL_DEF default upper clamp for raw samples
//   state_t       one-hot scanner states
package pir_pkg;

    localparam int LEVEL_W       = 7;
    localparam int NUM_CH        = 3;
    localparam int MAX_LEVEL_DEF = 100;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_START   = 5'b00010,
        ST_CONVERT = 5'b00100,
        ST_ACCUM   = 5'b01000,
        ST_NEXT    = 5'b10000
    } state_t;

endpackage

// File: rtl/pir_avg_channel.sv
// rtl/pir_avg_channel.sv - running average of one PIR channel
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset, clears history, sum and level
//   load    one-cycle strobe: push sample into history and refresh level
//   sample  clamped sample to accumulate
//   level   registered average of the last 2^AVG_LOG2 samples
module pir_avg_channel
    import pir_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [LEVEL_W-1:0] sample,
    output logic [LEVEL_W-1:0] level
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = LEVEL_W + AVG_LOG2;

    logic [LEVEL_W-1:0] hist_q [DEPTH];
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   sum_d;

    // The intermediate subtraction may wrap, but the final sum always fits
    // because it is the exact sum of DEPTH samples no wider than LEVEL_W.
    assign sum_d = sum_q - SUM_W'(hist_q[DEPTH-1]) + SUM_W'(sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else if (load) begin
            hist_q[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
            sum_q <= sum_d;
            level <= sum_d[SUM_W-1:AVG_LOG2];
        end
    end

endmodule

// File: rtl/pir_sensor_scanner.sv
// rtl/pir_sensor_scanner.sv - shared-ADC scanner with clamp and per-channel averaging
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable       scanning enable; low forces IDLE and clears tick/channel
//   adc_data     raw conversion result, used only with adc_done
//   adc_done     single-cycle conversion-complete strobe
//   adc_start    single-cycle conversion request (high in START)
//   adc_ch       channel under conversion, 0..2
//   pir_sensor_1 averaged level, channel 0
//   pir_sensor_2 averaged level, channel 1
//   pir_sensor_3 averaged level, channel 2
//   sample_valid one-cycle pulse after a complete scan
//   adc_fault    sticky ADC timeout flag, cleared only by reset
module pir_sensor_scanner
    import pir_pkg::*;
#(
    parameter int SAMPLE_DIV  = 50,
    parameter int AVG_LOG2    = 2,
    parameter int ADC_TIMEOUT = 31,
    parameter int MAX_LEVEL   = MAX_LEVEL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] adc_data,
    input  logic               adc_done,
    output logic               adc_start,
    output logic [1:0]         adc_ch,
    output logic [LEVEL_W-1:0] pir_sensor_1,
    output logic [LEVEL_W-1:0] pir_sensor_2,
    output logic [LEVEL_W-1:0] pir_sensor_3,
    output logic               sample_valid,
    output logic               adc_fault
);

    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int TMO_W  = $clog2(ADC_TIMEOUT + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(ADC_TIMEOUT - 1);
    localparam logic [LEVEL_W-1:0] MAX_L     = LEVEL_W'(MAX_LEVEL);
    localparam logic [1:0]         CH_LAST   = 2'(NUM_CH - 1);

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [1:0]         ch_q;
    logic [LEVEL_W-1:0] sample_q;
    logic               valid_q;
    logic               fault_q;
    logic               tick;
    logic               tmo_hit;
    logic [LEVEL_W-1:0] level [NUM_CH];

    assign tick    = enable && (tick_q == TICK_LAST);
    // The timeout fires on the last allowed CONVERT cycle; a done strobe in
    // that same cycle still wins.
    assign tmo_hit = (tmo_q == TMO_LAST) && !adc_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (tick) state_d = ST_START;
                ST_START:   state_d = ST_CONVERT;
                ST_CONVERT: begin
                    if (adc_done) begin
                        state_d = ST_ACCUM;
                    end else if (tmo_hit) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_ACCUM:   state_d = ST_NEXT;
                ST_NEXT:    state_d = (ch_q == CH_LAST) ? ST_IDLE : ST_START;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Tick counter runs freely while enabled; ticks seen outside IDLE are
    // simply not acted on, so they are dropped rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (!enable || tick_q == TICK_LAST) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q    <= '0;
            ch_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            valid_q <= enable && (state_q == ST_NEXT) && (ch_q == CH_LAST);

            if (!enable) begin
                ch_q  <= '0;
                tmo_q <= '0;
            end else begin
                case (state_q)
                    ST_START: tmo_q <= '0;
                    ST_CONVERT: begin
                        tmo_q <= tmo_q + TMO_W'(1);
                        if (adc_done) begin
                            sample_q <= (adc_data > MAX_L) ? MAX_L : adc_data;
                        end else if (tmo_hit) begin
                            fault_q <= 1'b1;
                        end
                    end
                    ST_NEXT: ch_q <= (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
                    default: ;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;
        assign load = enable && (state_q == ST_ACCUM) && (ch_q == 2'(i));

        pir_avg_channel #(
            .AVG_LOG2 (AVG_LOG2)
        ) u_avg (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load),
            .sample (sample_q),
            .level  (level[i])
        );
    end

    assign adc_start    = (state_q == ST_START);
    assign adc_ch       = ch_q;
    assign pir_sensor_1 = level[0];
    assign pir_sensor_2 = level[1];
    assign pir_sensor_3 = level[2];
    assign sample_valid = valid_q;
    assign adc_fault    = fault_q;

endmodule

// File: tb/tb_pir_sensor_scanner.sv
// tb/tb_pir_sensor_scanner.sv - self-checking bench for pir_sensor_scanner
module tb_pir_sensor_scanner;

    localparam int SAMPLE_DIV  = 50;
    localparam int AVG_LOG2    = 2;
    localparam int ADC_TIMEOUT = 31;
    localparam int MAX_LEVEL   = 100;
    localparam int DEPTH       = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] adc_data;
    logic       adc_done;
    logic       adc_start;
    logic [1:0] adc_ch;
    logic [6:0] pir_sensor_1;
    logic [6:0] pir_sensor_2;
    logic [6:0] pir_sensor_3;
    logic       sample_valid;
    logic       adc_fault;

    pir_sensor_scanner #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .AVG_LOG2    (AVG_LOG2),
        .ADC_TIMEOUT (ADC_TIMEOUT),
        .MAX_LEVEL   (MAX_LEVEL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .adc_data     (adc_data),
        .adc_done     (adc_done),
        .adc_start    (adc_start),
        .adc_ch       (adc_ch),
        .pir_sensor_1 (pir_sensor_1),
        .pir_sensor_2 (pir_sensor_2),
        .pir_sensor_3 (pir_sensor_3),
        .sample_valid (sample_valid),
        .adc_fault    (adc_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hist [3][DEPTH];
    int exp_fault;
    int wait_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: level is the truncated mean of the last DEPTH clamped samples.
    function automatic void model_clear();
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < DEPTH; k++)
                hist[c][k] = 0;
    endfunction

    function automatic void model_push(input int c, input int v);
        for (int k = DEPTH - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = (v > MAX_LEVEL) ? MAX_LEVEL : v;
    endfunction

    function automatic int model_level(input int c);
        int s = 0;
        for (int k = 0; k < DEPTH; k++) s += hist[c][k];
        return s / DEPTH;
    endfunction

    function automatic logic [6:0] dut_level(input int c);
        case (c)
            0:       return pir_sensor_1;
            1:       return pir_sensor_2;
            default: return pir_sensor_3;
        endcase
    endfunction

    task automatic wait_start();
        bit seen = 0;
        wait_cycles = 0;
        while (!seen && wait_cycles < 300) begin
            @(negedge clk);
            wait_cycles++;
            if (adc_start) seen = 1;
        end
        check("adc_start_seen", adc_start, 1);
    endtask

    // lat = cycles after START until adc_done; 0 means the ADC never answers.
    // Returns on the NEXT-state cycle of channel c.
    task automatic do_channel(input int c, input int v, input int lat, input bit need_wait);
        if (need_wait) wait_start();
        if (!adc_start) return;
        check($sformatf("adc_ch_%0d", c), adc_ch, c);
        if (lat == 0) begin
            repeat (ADC_TIMEOUT) @(negedge clk);
            check("fault_not_early", adc_fault, exp_fault);
            @(negedge clk);
            exp_fault = 1;
            check("fault_on_timeout", adc_fault, 1);
            check($sformatf("level_hold_tmo_%0d", c), dut_level(c), model_level(c));
        end else begin
            repeat (lat) @(negedge clk);
            adc_data = 7'(v);
            adc_done = 1'b1;
            @(negedge clk);
            adc_done = 1'b0;
            adc_data = 7'($urandom);
            check($sformatf("level_pre_%0d", c), dut_level(c), model_level(c));
            model_push(c, v);
            @(negedge clk);
            check($sformatf("level_%0d", c), dut_level(c), model_level(c));
            check("fault_flag", adc_fault, exp_fault);
        end
    endtask

    task automatic end_scan();
        check("valid_low_in_next", sample_valid, 0);
        @(negedge clk);
        check("valid_pulse", sample_valid, 1);
        @(negedge clk);
        check("valid_width", sample_valid, 0);
    endtask

    task automatic scan(input int v0, input int v1, input int v2,
                        input int l0, input int l1, input int l2);
        do_channel(0, v0, l0, 1);
        do_channel(1, v1, l1, 1);
        do_channel(2, v2, l2, 1);
        end_scan();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, adc_start, 0);
        check({tag, "_ch"}, adc_ch, 0);
        check({tag, "_pir1"}, pir_sensor_1, 0);
        check({tag, "_pir2"}, pir_sensor_2, 0);
        check({tag, "_pir3"}, pir_sensor_3, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_fault"}, adc_fault, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        rst_n     = 1'b0;
        enable    = 1'b0;
        adc_done  = 1'b0;
        adc_data  = '0;
        exp_fault = 0;
        model_clear();

        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // First scan begins a full SAMPLE_DIV after reset release.
        enable = 1'b1;
        rst_n  = 1'b1;
        wait_start();
        check("first_scan_delay", wait_cycles, SAMPLE_DIV);
        do_channel(0, 40, 3, 0);
        do_channel(1, 120, 3, 1);
        do_channel(2, 40, 3, 1);
        end_scan();
        check("scan1_pir1", pir_sensor_1, 10);
        check("scan1_pir2", pir_sensor_2, 25);

        for (int s = 2; s <= 4; s++) scan(40, 120, 40, 3, 3, 3);
        check("scan4_pir1", pir_sensor_1, 40);
        check("scan4_pir2", pir_sensor_2, 100);
        check("scan4_pir3", pir_sensor_3, 40);

        // Channel 0 sequence 0,0,0,0,80; channel 1 stays clamped at 100.
        for (int s = 0; s < 5; s++) scan((s == 4) ? 80 : 0, 120, 40, 1, 2, 1);
        check("seq_pir1", pir_sensor_1, 20);
        check("clamp_pir2", pir_sensor_2, 100);

        // Randomized scans against the reference model.
        for (int s = 0; s < 6; s++)
            scan($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
                 $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));

        // adc_done on the very cycle the timeout would fire counts as done.
        scan($urandom_range(0, 127), 50, 60, ADC_TIMEOUT, 1, 1);
        check("boundary_no_fault", adc_fault, 0);

        // Channel 2 never answers.
        scan($urandom_range(0, 127), $urandom_range(0, 127), 0, 2, 2, 0);
        scan($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), 1, 3, 2);
        check("fault_sticky", adc_fault, 1);

        // Drop enable during channel 1 CONVERT.
        do_channel(0, $urandom_range(0, 127), 2, 1);
        wait_start();
        check("abort_ch1", adc_ch, 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_start", adc_start, 0);
        check("abort_ch_clr", adc_ch, 0);
        check("abort_valid", sample_valid, 0);
        adc_data = 7'd127;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        starts = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (adc_start) starts++;
        end
        check("no_start_disabled", starts, 0);
        for (int c = 0; c < 3; c++)
            check($sformatf("abort_hold_%0d", c), dut_level(c), model_level(c));
        check("abort_fault_hold", adc_fault, 1);

        enable = 1'b1;
        wait_start();
        check("reenable_delay", wait_cycles, SAMPLE_DIV);
        do_channel(0, $urandom_range(0, 127), 1, 0);
        do_channel(1, $urandom_range(0, 127), 4, 1);
        do_channel(2, $urandom_range(0, 127), 2, 1);
        end_scan();

        // Asynchronous reset in the middle of channel 1 CONVERT.
        do_channel(0, 90, 1, 1);
        wait_start();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        exp_fault = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_start();
        check("post_reset_delay", wait_cycles, SAMPLE_DIV);
        do_channel(0, 40, 1, 0);
        do_channel(1, 40, 1, 1);
        do_channel(2, 40, 1, 1);
        end_scan();
        check("post_reset_pir3", pir_sensor_3, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
